// File: rtl/ICEAppTypes.sv
// rtl/ICEAppTypes.sv - shared state encoding and Fletcher-32 helpers
package ICEAppTypes;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PIXELS,
      ST_CKSUM_LO,
      ST_CKSUM_HI,
      ST_PADDING,
      ST_DONE
   } state_t;

   localparam logic [16:0] FLETCHER_MOD = 17'd65535;

   // One modular add; both operands are below 2^16 so a single subtract suffices.
   function automatic logic [15:0] fletcher_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= FLETCHER_MOD) s = s - FLETCHER_MOD;
      return s[15:0];
   endfunction

endpackage

// File: rtl/fletcher32_acc.sv
// rtl/fletcher32_acc.sv - Fletcher-32 running sum over 16-bit words
module fletcher32_acc
   import ICEAppTypes::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] word,
   output logic [31:0] sum
);

   logic [15:0] s1;
   logic [15:0] s2;
   logic [15:0] s1_next;

   assign s1_next = fletcher_add(s1, word);

   always_ff @(posedge clk) begin
      if (clr) begin
         s1 <= 16'd0;
         s2 <= 16'd0;
      end else if (en) begin
         s1 <= s1_next;
         s2 <= fletcher_add(s2, s1_next);
      end
   end

   assign sum = {s2, s1};

endmodule

// File: rtl/img_readout_checker.sv
// rtl/img_readout_checker.sv - checks a header/pixel/checksum/padding readout stream
module img_readout_checker
   import ICEAppTypes::*;
#(
   parameter int HeaderWordCount       = 32,
   parameter int ImgWidth              = 2304,
   parameter int ImgHeight             = 1296,
   parameter int ThumbWidth            = 288,
   parameter int ThumbHeight           = 162,
   parameter int PaddingWordCount      = 0,
   parameter int ThumbPaddingWordCount = 0,
   parameter int PixelBits             = 12
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic        cfg_thumb,
   input  logic [15:0] cfg_pixelInitial,
   input  logic [15:0] cfg_pixelDelta,
   input  logic [15:0] cfg_filterPeriod,
   input  logic [15:0] cfg_filterKeep,
   input  logic        in_ready,
   input  logic        in_trigger,
   input  logic [15:0] in_data,
   output logic        status_busy,
   output logic        status_done,
   output logic        status_pass,
   output logic [15:0] status_errCount,
   output logic [31:0] status_firstErrIdx,
   output logic [31:0] status_wordCount,
   output logic [31:0] status_checksum
);

   localparam logic [31:0] HDR_LAST  = 32'(HeaderWordCount - 1);
   localparam logic [31:0] IMG_PIX   = 32'(ImgWidth * ImgHeight);
   localparam logic [31:0] THUMB_PIX = 32'(ThumbWidth * ThumbHeight);
   localparam logic [31:0] IMG_PAD   = 32'(PaddingWordCount);
   localparam logic [31:0] THUMB_PAD = 32'(ThumbPaddingWordCount);
   localparam logic [15:0] PIX_MASK  = 16'((32'd1 << PixelBits) - 32'd1);

   state_t      state, state_next;
   logic        thumb_q;
   logic [15:0] delta_q, period_q, keep_q;
   logic [15:0] exp_q, phase_q;
   logic [31:0] cnt_q, cnt_next;
   logic [15:0] err_next;

   logic        xfer, counted, mismatch, fold, pix_step, compare_en;
   logic [31:0] pix_last, pad_total;

   assign xfer       = in_ready && in_trigger;
   assign pix_last   = (thumb_q ? THUMB_PIX : IMG_PIX) - 32'd1;
   assign pad_total  = thumb_q ? THUMB_PAD : IMG_PAD;
   assign compare_en = (period_q == 16'd0) || (phase_q < keep_q);

   always_comb begin
      state_next = state;
      cnt_next   = cnt_q;
      counted    = 1'b0;
      mismatch   = 1'b0;
      fold       = 1'b0;
      pix_step   = 1'b0;
      if (cfg_start) begin
         state_next = ST_HEADER;
         cnt_next   = 32'd0;
      end else if (xfer) begin
         case (state)
            ST_HEADER: begin
               counted = 1'b1;
               fold    = 1'b1;
               if (cnt_q == HDR_LAST) begin
                  state_next = ST_PIXELS;
                  cnt_next   = 32'd0;
               end else begin
                  cnt_next = cnt_q + 32'd1;
               end
            end
            ST_PIXELS: begin
               counted  = 1'b1;
               fold     = 1'b1;
               pix_step = 1'b1;
               mismatch = compare_en && (in_data != exp_q);
               if (cnt_q == pix_last) begin
                  state_next = ST_CKSUM_LO;
                  cnt_next   = 32'd0;
               end else begin
                  cnt_next = cnt_q + 32'd1;
               end
            end
            ST_CKSUM_LO: begin
               counted    = 1'b1;
               mismatch   = in_data != status_checksum[15:0];
               state_next = ST_CKSUM_HI;
            end
            ST_CKSUM_HI: begin
               counted    = 1'b1;
               mismatch   = in_data != status_checksum[31:16];
               state_next = (pad_total == 32'd0) ? ST_DONE : ST_PADDING;
               cnt_next   = 32'd0;
            end
            ST_PADDING: begin
               counted = 1'b1;
               if (cnt_q == pad_total - 32'd1) begin
                  state_next = ST_DONE;
                  cnt_next   = 32'd0;
               end else begin
                  cnt_next = cnt_q + 32'd1;
               end
            end
            ST_DONE: begin
               // Overrun: anything after the frame is an error but does not leave DONE.
               counted  = 1'b1;
               mismatch = 1'b1;
            end
            default: begin
               state_next = state;
            end
         endcase
      end

      if (cfg_start)
         err_next = 16'd0;
      else if (mismatch && status_errCount != 16'hFFFF)
         err_next = status_errCount + 16'd1;
      else
         err_next = status_errCount;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         cnt_q              <= 32'd0;
         thumb_q            <= 1'b0;
         delta_q            <= 16'd0;
         period_q           <= 16'd0;
         keep_q             <= 16'd0;
         exp_q              <= 16'd0;
         phase_q            <= 16'd0;
         status_busy        <= 1'b0;
         status_done        <= 1'b0;
         status_pass        <= 1'b0;
         status_errCount    <= 16'd0;
         status_firstErrIdx <= 32'hFFFF_FFFF;
         status_wordCount   <= 32'd0;
      end else begin
         state           <= state_next;
         cnt_q           <= cnt_next;
         status_errCount <= err_next;
         status_busy     <= (state_next != ST_IDLE) && (state_next != ST_DONE);
         status_done     <= (state_next == ST_DONE);
         status_pass     <= (state_next == ST_DONE) && (err_next == 16'd0);
         if (cfg_start) begin
            thumb_q            <= cfg_thumb;
            delta_q            <= cfg_pixelDelta;
            period_q           <= cfg_filterPeriod;
            keep_q             <= cfg_filterKeep;
            exp_q              <= cfg_pixelInitial & PIX_MASK;
            phase_q            <= 16'd0;
            status_firstErrIdx <= 32'hFFFF_FFFF;
            status_wordCount   <= 32'd0;
         end else begin
            if (counted) status_wordCount <= status_wordCount + 32'd1;
            if (mismatch && status_errCount == 16'd0) status_firstErrIdx <= status_wordCount;
            if (pix_step) begin
               exp_q   <= (exp_q + delta_q) & PIX_MASK;
               phase_q <= (phase_q + 16'd1 == period_q) ? 16'd0 : phase_q + 16'd1;
            end
         end
      end
   end

   fletcher32_acc u_acc (
      .clk  (clk),
      .clr  (rst || cfg_start),
      .en   (fold),
      .word (in_data),
      .sum  (status_checksum)
   );

endmodule

// File: doc/img_readout_checker.md
IMG_READOUT_CHECKER -- requirements
Module: img_readout_checker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- HeaderWordCount, 32, header words per image
- ImgWidth, 2304, full-image width in pixels
- ImgHeight, 1296, full-image height in pixels
- ThumbWidth, 288, thumbnail width
- ThumbHeight, 162, thumbnail height
- PaddingWordCount, 0, padding words after a full image
- ThumbPaddingWordCount, 0, padding words after a thumbnail
- PixelBits, 12, significant pixel bits; upper data bits SHALL be zero
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, synchronous active-high reset
- cfg_start, in, 1, one-cycle pulse that arms a new check
- cfg_thumb, in, 1, selects thumbnail geometry; sampled on cfg_start
- cfg_pixelInitial, in, 16, expected first pixel; sampled on cfg_start
- cfg_pixelDelta, in, 16, signed per-pixel increment; sampled on cfg_start
- cfg_filterPeriod, in, 16, pixel filter period (0 = compare every pixel)
- cfg_filterKeep, in, 16, pixels compared at the start of each period
- in_ready, in, 1, data valid from the readout source
- in_trigger, in, 1, consumer accept; a word transfers when in_ready && in_trigger
- in_data, in, 16, readout word
- status_busy, out, 1, check in progress
- status_done, out, 1, check complete; sticky until the next cfg_start or rst
- status_pass, out, 1, valid while done; 1 iff errCount==0
- status_errCount, out, 16, mismatch count, saturating at 16'hFFFF
- status_firstErrIdx, out, 32, word index of the first mismatch; all-ones if none
- status_wordCount, out, 32, words transferred since cfg_start
- status_checksum, out, 32, computed Fletcher-32

Function
REQ-003 The FSM SHALL have the states IDLE, HEADER, PIXELS, CKSUM_LO, CKSUM_HI, PADDING and DONE, and SHALL advance only on a transfer cycle.
REQ-004 A cfg_start pulse in any state SHALL clear all counters and status, latch the cfg_* inputs, and enter HEADER on the next cycle.
REQ-005 HEADER SHALL accept HeaderWordCount words with no value check, fold them into the checksum, then enter PIXELS.
REQ-006 PIXELS SHALL accept W*H words, where (W,H) is (ThumbWidth,ThumbHeight) when the latched thumb flag is 1 and (ImgWidth,ImgHeight) otherwise.
REQ-007 The expected pixel SHALL start at pixelInitial, advance by pixelDelta after each pixel, wrap modulo 2^PixelBits, and be zero-extended to 16 bits.
REQ-008 A pixel SHALL be compared only when filterPeriod==0 or (pixel index mod filterPeriod) < filterKeep; the expected value SHALL advance on every pixel, compared or not.
REQ-009 The checksum SHALL be Fletcher-32 over the header and pixel words: s1=(s1+w) mod 65535, then s2=(s2+s1) mod 65535, with s1=s2=0 at start; status_checksum={s2,s1}.
REQ-010 CKSUM_LO SHALL compare in_data against s1, and CKSUM_HI SHALL compare in_data against s2; neither word SHALL be folded into the checksum.
REQ-011 PADDING SHALL accept the padding count for the selected mode with no value check; a count of 0 SHALL skip directly from CKSUM_HI to DONE.
REQ-012 Each mismatch SHALL increment errCount (saturating) and, if it is the first mismatch, record status_wordCount as firstErrIdx.
REQ-013 Any transfer while in DONE SHALL count as an overrun error, increment errCount and wordCount, and SHALL NOT leave DONE.
REQ-014 Transfers in IDLE SHALL be ignored.
REQ-015 The status outputs SHALL be registered and SHALL reflect a transfer one cycle after it occurs.
REQ-016 status_done SHALL assert one cycle after the final padding word (or the CKSUM_HI word when padding is 0).
REQ-017 status_busy SHALL be high in every state from HEADER through PADDING.

Reset
REQ-018 When rst is high, the FSM SHALL go to IDLE and the outputs SHALL take these values: busy=0, done=0, pass=0, errCount=0, firstErrIdx=all-ones, wordCount=0, checksum=0.
REQ-019 rst SHALL take priority over a simultaneous cfg_start.
REQ-020 A reset during a check SHALL abandon that check without asserting done.

Structure
REQ-021 The state encoding and the Fletcher modulus constant SHALL live in the shared ICEAppTypes package.
REQ-022 The Fletcher-32 accumulator SHALL be a separate sub-module, fletcher32_acc, with clr, en, word, and sum outputs.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Full image, 32 header words, pixels 0xFFF descending by 1, correct checksum, 0 padding, random in_trigger -> done=1, pass=1, wordCount=32+W*H+2.
- Thumbnail with ThumbPaddingWordCount=2 and the same pattern -> done=1, pass=1, wordCount=32+288*162+4.
- Pixel index 5 corrupted -> errCount=1, firstErrIdx=37, pass=0.
- filterPeriod=4, filterKeep=1, with pixels 1-3 of each period corrupted -> pass=1.
- Checksum high word flipped -> errCount=1; three extra words after done -> errCount=4.
- rst asserted mid-PIXELS, then a clean run restarted with cfg_start -> outputs at reset values, then pass=1.
